// File: rtl/alu_sequencer.sv
// Multicycle ALU execution sequencer: single-cycle add/sub/move/swap, iterated
// shift-add multiply and restoring divide, with a held two-word result.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOVE = 3'b100,
    OP_SWAP = 3'b101,
    OP_RSVD = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {partial_hi, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] work_q, work_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   result_lo_q, result_lo_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               dbz_q, dbz_d;

  op_e                op;
  logic               accept;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign op       = op_e'(operation);
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dbz_q;

  // Datapath for one iteration step of each iterated operation.
  always_comb begin
    add_full  = {1'b0, op_a} + {1'b0, op_b};
    sub_diff  = op_a - op_b;

    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]}
              + (work_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};

    div_shift = work_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, operand_q};
    div_ge    = (div_shift >= {1'b0, operand_q});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 work_q[WIDTH-2:0], div_ge};
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    operand_d   = operand_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          unique case (op)
            OP_ADD: begin
              state_d     = DONE;
              result_lo_d = add_full[WIDTH-1:0];
              result_hi_d = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
            end
            OP_SUB: begin
              state_d     = DONE;
              result_lo_d = sub_diff;
              result_hi_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            end
            OP_MOVE: begin
              state_d     = DONE;
              result_lo_d = op_a;
              result_hi_d = '0;
            end
            OP_SWAP: begin
              state_d     = DONE;
              result_lo_d = op_b;
              result_hi_d = op_a;
            end
            OP_MUL: begin
              state_d   = MUL;
              cnt_d     = CNT_W'(WIDTH);
              work_d    = {{WIDTH{1'b0}}, op_b};
              operand_d = op_a;
            end
            OP_DIV: begin
              if (op_b == '0) begin
                state_d     = DONE;
                result_lo_d = '1;
                result_hi_d = op_a;
                dbz_d       = 1'b1;
              end else begin
                state_d   = DIV;
                cnt_d     = CNT_W'(WIDTH);
                work_d    = {{WIDTH{1'b0}}, op_a};
                operand_d = op_b;
              end
            end
            OP_RSVD, OP_NOP: begin
              state_d = IDLE;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end

      MUL: begin
        work_d = mul_next;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          result_lo_d = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[2*WIDTH-1:WIDTH];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DIV: begin
        work_d = div_next;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          result_lo_d = div_next[WIDTH-1:0];
          result_hi_d = div_next[2*WIDTH-1:WIDTH];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; blocking here would race.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      operand_q   <= '0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      operand_q   <= operand_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: one task per scenario, hand-computed
// expected values, single summary line at the end.
module tb_alu_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   operation;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;
  logic         busy;

  int total = 0;
  int bad   = 0;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issue one op, measure latency, check results, optionally stall out_ready.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input logic exp_dbz,
                        input int hold);
    int n;
    int g;
    out_ready = (hold == 0);
    operation = op;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    op_a      = ~a;
    op_b      = ~b;
    operation = 3'b000;

    n = 1;
    while (!out_valid && n < 40) begin
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s running: busy=%b in_ready=%b required busy=1 in_ready=0",
                 name, busy, in_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, exp_lat);
    end
    if (out_valid !== 1'b1) return;

    total++;
    if (result_lo !== exp_lo || result_hi !== exp_hi || div_by_zero !== exp_dbz) begin
      bad++;
      $display("FAIL %s result: lo=%h hi=%h dbz=%b required lo=%h hi=%h dbz=%b",
               name, result_lo, result_hi, div_by_zero, exp_lo, exp_hi, exp_dbz);
    end
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s done flags: busy=%b in_ready=%b required 1/0", name, busy, in_ready);
    end

    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_lo !== exp_lo ||
            result_hi !== exp_hi) begin
          bad++;
          $display("FAIL %s hold[%0d]: valid=%b rdy=%b lo=%h hi=%h required 1/0 lo=%h hi=%h",
                   name, i, out_valid, in_ready, result_lo, result_hi, exp_lo, exp_hi);
        end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || result_lo !== exp_lo || result_hi !== exp_hi) begin
        bad++;
        $display("FAIL %s hold last: valid=%b lo=%h hi=%h required 1 lo=%h hi=%h",
                 name, out_valid, result_lo, result_hi, exp_lo, exp_hi);
      end
    end

    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        result_lo !== exp_lo || result_hi !== exp_hi) begin
      bad++;
      $display("FAIL %s after handshake: valid=%b rdy=%b busy=%b lo=%h hi=%h required 0/1/0 lo=%h hi=%h",
               name, out_valid, in_ready, busy, result_lo, result_hi, exp_lo, exp_hi);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = 3'b111;
    op_a      = '0;
    op_b      = '0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0 ||
        div_by_zero !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset state: valid=%b lo=%h hi=%h dbz=%b busy=%b rdy=%b required all 0",
               out_valid, result_lo, result_hi, div_by_zero, busy, in_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    run_op("add", 3'b000, 8'hF0, 8'h20, 1, 8'h10, 8'h01, 1'b0, 0);
    run_op("sub", 3'b001, 8'h05, 8'h07, 1, 8'hFE, 8'h01, 1'b0, 0);
    run_op("sub_noborrow", 3'b001, 8'h07, 8'h05, 1, 8'h02, 8'h00, 1'b0, 0);
  endtask

  task automatic test_mult();
    run_op("mult_200x3", 3'b010, 8'd200, 8'd3, 9, 8'h58, 8'h02, 1'b0, 0);
    run_op("mult_ffxff", 3'b010, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1'b0, 0);
  endtask

  task automatic test_div();
    run_op("div_100_7", 3'b011, 8'd100, 8'd7, 9, 8'h0E, 8'h02, 1'b0, 0);
    run_op("div_ff_10", 3'b011, 8'hFF, 8'h10, 9, 8'h0F, 8'h0F, 1'b0, 0);
    run_op("div_by_zero", 3'b011, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 1'b1, 0);
  endtask

  task automatic test_nop();
    logic [2:0] codes [2];
    codes[0] = 3'b111;
    codes[1] = 3'b110;
    for (int k = 0; k < 2; k++) begin
      operation = codes[k];
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL nop %b: valid=%b rdy=%b busy=%b dbz=%b required 0/1/0/0",
                 codes[k], out_valid, in_ready, busy, div_by_zero);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL nop quiet[%0d]: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_swap_move();
    run_op("swap_hold", 3'b101, 8'h12, 8'h34, 1, 8'h34, 8'h12, 1'b0, 5);
    run_op("move", 3'b100, 8'hA5, 8'h3C, 1, 8'hA5, 8'h00, 1'b0, 0);
  endtask

  task automatic test_reset_mid_mult();
    out_ready = 1'b1;
    operation = 3'b010;
    op_a      = 8'd200;
    op_b      = 8'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL pre-abort: busy=%b required 1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0 ||
        div_by_zero !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async abort: valid=%b lo=%h hi=%h dbz=%b busy=%b rdy=%b required all 0",
               out_valid, result_lo, result_hi, div_by_zero, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort release: rdy=%b busy=%b valid=%b required 1/0/0",
               in_ready, busy, out_valid);
    end
    run_op("add_after_abort", 3'b000, 8'h01, 8'h01, 1, 8'h02, 8'h00, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mult();
    test_div();
    test_nop();
    test_swap_move();
    test_reset_mid_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multicycle execution sequencer that sits behind the ALU operation decoder. It accepts one decoded 3-bit operation plus two operands over a valid/ready handshake and runs the operation. Single-cycle ops complete directly; multiply and divide are iterated over WIDTH cycles. It holds a two-word result until the consumer accepts it.

Parameters:
WIDTH, 8, operand width in bits (>=2); also the iteration count for mult/div

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation/operands offered
in_ready  output  1  sequencer can accept (IDLE and reset low)
operation  input  3  000 add, 001 sub, 010 mult, 011 div, 100 move, 101 swap, 111 nop; 110 treated as nop
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
out_valid  output  1  result_lo/result_hi/div_by_zero valid
out_ready  input  1  consumer accepts result
result_lo  output  WIDTH  low result word
result_hi  output  WIDTH  high result word
div_by_zero  output  1  last div had op_b==0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state, including mid-iteration):
  - state=IDLE; out_valid=0, result_lo=0, result_hi=0, div_by_zero=0, busy=0; iteration counter and partials cleared.
  - in_ready=0 while reset is high.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid & in_ready at an edge (only in IDLE). Operation and operands are captured. in_ready=0 in MUL/DIV/DONE, so there is no overlap.
- From IDLE on accept, the next state and results are:
  - add -> DONE; lo=(a+b) mod 2^W, hi={0..0,carry}.
  - sub -> DONE; lo=(a-b) mod 2^W, hi={0..0,borrow}, where borrow=(a<b).
  - move -> DONE; lo=a, hi=0.
  - swap -> DONE; lo=b, hi=a.
  - mult -> MUL; counter=WIDTH.
  - div with b!=0 -> DIV; counter=WIDTH.
  - div with b==0 -> DONE; lo=all ones, hi=a, div_by_zero=1.
  - nop/110 -> stay IDLE; no output is produced, in_ready stays 1 next cycle.
- div_by_zero is cleared on every accept and is set only as described above.
- MUL:
  - Unsigned WxW shift-add, one partial step per cycle; counter decrements each cycle.
  - After WIDTH cycles -> DONE with {hi,lo} = 2W-bit product.
- DIV:
  - Unsigned restoring division, one quotient bit per cycle.
  - After WIDTH cycles -> DONE with lo=quotient, hi=remainder.
- Latency (accept edge T):
  - Single-cycle ops and div-by-zero: out_valid=1 in the cycle after T.
  - mult/div: out_valid=1 WIDTH+1 cycles after T.
- DONE:
  - out_valid=1; result_lo, result_hi and div_by_zero are held stable while out_ready=0.
  - On out_valid & out_ready -> IDLE, out_valid=0 next cycle; results keep their last values.
  - The earliest next accept is the cycle after the handshake.
- Operands and operation are sampled only at accept. Input changes afterward have no effect.
- busy=1 in MUL, DIV and DONE.
- Counter width is clog2(WIDTH)+1. The counter never wraps; terminal count 1 triggers the transition to DONE.

Test Plan:
- add a=8'hF0, b=8'h20, out_ready=1 -> out_valid 1 cycle after accept; lo=8'h10, hi=8'h01. Then sub a=8'h05, b=8'h07 -> lo=8'hFE, hi=8'h01.
- mult a=8'd200, b=8'd3 -> out_valid exactly 9 cycles after accept; hi=8'h02, lo=8'h58; in_ready=0 and busy=1 throughout. Then mult 8'hFF*8'hFF -> hi=8'hFE, lo=8'h01.
- div a=8'd100, b=8'd7 -> out_valid 9 cycles after accept; lo=8'h0E, hi=8'h02, div_by_zero=0. Then div a=8'h55, b=0 -> out_valid 1 cycle after accept; lo=8'hFF, hi=8'h55, div_by_zero=1.
- swap a=8'h12, b=8'h34 with out_ready held low 5 cycles -> lo=8'h34, hi=8'h12 stable all 5 cycles; in_ready=0; handshake on cycle 6 returns to IDLE. move a=8'hA5 -> lo=8'hA5, hi=0.
- nop (111) and code 110 -> accepted; out_valid never rises; in_ready=1 on the following cycle.
- reset asserted on 4th MUL cycle -> outputs zero immediately (async); after release in_ready=1. A new add 1+1 gives lo=8'h02 with no residue from the aborted mult.
